wb_stage_param: RTL and testbench

Parametrised writeback stage for the pipelined RISC-V core. It succeeds the two-input ALU/memory writeback mux with a four-source selector, load-data alignment and sign/zero extension, and a registered register-file write port. It also provides a valid/ready handshake that stalls MEM/WB while a load response is outstanding, a flush input, and a retired-instruction counter. It sits between the MEM/WB pipeline boundary and the register-file write port.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_stage_param_load_extender.sv | 58 +++++
 rtl/wb_stage_param.sv | 177 +++++++++++++++++
 tb/tb_wb_stage_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   - Writeback source select codes (2-bit).
//   - Load funct3 codes.
//   - Writeback FSM state type.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_IMM = 2'b11;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_param_load_extender.sv
// load_extender: combinational load-data alignment and sign/zero extension.
// Ports:
//   raw_data  in  XLEN   raw memory word
//   offset    in  2|3    byte offset within the word (3 bits when XLEN = 64)
//   load_type in  3      load funct3
//   ext_data  out XLEN   aligned and extended value
// Codes that the configured XLEN does not support return the raw word.
module load_extender
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]                  raw_data,
    input  logic [((XLEN == 64) ? 3 : 2)-1:0] offset,
    input  logic [2:0]                       load_type,
    output logic [XLEN-1:0]                  ext_data
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword selection ignores offset bit 0, so misaligned halves snap down.
    assign byte_sel = raw_data[{offset, 3'b000} +: 8];
    assign half_sel = raw_data[{offset[OFF_W-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_rv64
            logic [31:0] word_sel;
            assign word_sel = raw_data[{offset[2], 5'b00000} +: 32];

            always_comb begin
                case (load_type)
                    LD_B:    ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                    LD_BU:   ext_data = {{(XLEN-8){1'b0}}, byte_sel};
                    LD_H:    ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
                    LD_HU:   ext_data = {{(XLEN-16){1'b0}}, half_sel};
                    LD_W:    ext_data = {{(XLEN-32){word_sel[31]}}, word_sel};
                    LD_WU:   ext_data = {{(XLEN-32){1'b0}}, word_sel};
                    default: ext_data = raw_data;  // LD and the reserved code
                endcase
            end
        end else begin : g_rv32
            // On RV32 a word load is the whole raw word, so LW shares the default.
            always_comb begin
                case (load_type)
                    LD_B:    ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                    LD_BU:   ext_data = {{(XLEN-8){1'b0}}, byte_sel};
                    LD_H:    ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
                    LD_HU:   ext_data = {{(XLEN-16){1'b0}}, half_sel};
                    default: ext_data = raw_data;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/wb_stage_param.sv
// wb_stage_param: parametrised writeback stage.
// Selects ALU / MEM / PC+4 / IMM as the writeback value, aligns and extends
// load data, and drives a registered register-file write port. A load whose
// memory response is not yet valid parks the stage in WAIT_MEM (ready low)
// until the response arrives. Also counts retired instructions.
// Ports:
//   clock, reset (sync, active-high)
//   valid_WB_in / ready_WB_out     MEM/WB handshake
//   flush_WB_in                    kill the accepted or pending instruction
//   regWrite/wbSel/loadType/rd     instruction control fields
//   ALU_result/pcPlus4/imm         datapath sources (ALU_result is the load address)
//   readData/readValid             memory response
//   regWrite/rd/writeData_WB_out   registered register-file write port
//   loadWait_WB_out                high while waiting for a load response
//   instret_WB_out                 retired-instruction count (wraps)
module wb_stage_param
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 64,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_WB_in,
    output logic              ready_WB_out,
    input  logic              flush_WB_in,
    input  logic              regWrite_WB_in,
    input  logic [1:0]        wbSel_WB_in,
    input  logic [2:0]        loadType_WB_in,
    input  logic [REG_AW-1:0] rd_WB_in,
    input  logic [XLEN-1:0]   ALU_result_WB_in,
    input  logic [XLEN-1:0]   pcPlus4_WB_in,
    input  logic [XLEN-1:0]   imm_WB_in,
    input  logic [XLEN-1:0]   readData_WB_in,
    input  logic              readValid_WB_in,
    output logic              regWrite_WB_out,
    output logic [REG_AW-1:0] rd_WB_out,
    output logic [XLEN-1:0]   writeData_WB_out,
    output logic              loadWait_WB_out,
    output logic [CNT_W-1:0]  instret_WB_out
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    wb_state_t         state_q, state_d;
    logic              cap_rw_q, cap_rw_d;
    logic [2:0]        cap_lt_q, cap_lt_d;
    logic [REG_AW-1:0] cap_rd_q, cap_rd_d;
    logic [OFF_W-1:0]  cap_off_q, cap_off_d;

    logic              rw_out_q, rw_out_d;
    logic [REG_AW-1:0] rd_out_q, rd_out_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic              accept;
    logic              retire;
    logic              ret_rw;
    logic [REG_AW-1:0] ret_rd;
    logic [XLEN-1:0]   ret_data;
    logic [XLEN-1:0]   live_data;
    logic [OFF_W-1:0]  ext_off;
    logic [2:0]        ext_type;
    logic [XLEN-1:0]   ext_data;

    // A waited load must be extended with the fields captured at acceptance,
    // since the MEM/WB inputs may already describe a different instruction.
    assign ext_off  = (state_q == WAIT_MEM) ? cap_off_q : ALU_result_WB_in[OFF_W-1:0];
    assign ext_type = (state_q == WAIT_MEM) ? cap_lt_q  : loadType_WB_in;

    load_extender #(
        .XLEN (XLEN)
    ) u_load_extender (
        .raw_data  (readData_WB_in),
        .offset    (ext_off),
        .load_type (ext_type),
        .ext_data  (ext_data)
    );

    always_comb begin
        case (wbSel_WB_in)
            WB_SEL_ALU: live_data = ALU_result_WB_in;
            WB_SEL_MEM: live_data = ext_data;
            WB_SEL_PC4: live_data = pcPlus4_WB_in;
            default:    live_data = imm_WB_in;
        endcase
    end

    // Output process of the FSM.
    always_comb begin
        ready_WB_out    = (state_q == IDLE);
        loadWait_WB_out = (state_q == WAIT_MEM);
    end

    assign accept = valid_WB_in && ready_WB_out;

    // Next-state process: state, capture fields and retire decision.
    always_comb begin
        state_d   = state_q;
        cap_rw_d  = cap_rw_q;
        cap_lt_d  = cap_lt_q;
        cap_rd_d  = cap_rd_q;
        cap_off_d = cap_off_q;
        retire    = 1'b0;
        ret_rw    = regWrite_WB_in;
        ret_rd    = rd_WB_in;
        ret_data  = live_data;
        case (state_q)
            IDLE: begin
                if (accept && !flush_WB_in) begin
                    if ((wbSel_WB_in != WB_SEL_MEM) || readValid_WB_in) begin
                        retire = 1'b1;
                    end else begin
                        cap_rw_d  = regWrite_WB_in;
                        cap_lt_d  = loadType_WB_in;
                        cap_rd_d  = rd_WB_in;
                        cap_off_d = ALU_result_WB_in[OFF_W-1:0];
                        state_d   = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // Flush wins over a same-cycle response.
                if (flush_WB_in) begin
                    state_d = IDLE;
                end else if (readValid_WB_in) begin
                    retire   = 1'b1;
                    ret_rw   = cap_rw_q;
                    ret_rd   = cap_rd_q;
                    ret_data = ext_data;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port: enable pulses only on retire; index/data hold otherwise.
    always_comb begin
        rw_out_d  = retire && ret_rw && (ret_rd != '0);
        rd_out_d  = retire ? ret_rd   : rd_out_q;
        wdata_d   = retire ? ret_data : wdata_q;
        instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
    end

    // State register process.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cap_rw_q  <= 1'b0;
            cap_lt_q  <= '0;
            cap_rd_q  <= '0;
            cap_off_q <= '0;
            rw_out_q  <= 1'b0;
            rd_out_q  <= '0;
            wdata_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cap_rw_q  <= cap_rw_d;
            cap_lt_q  <= cap_lt_d;
            cap_rd_q  <= cap_rd_d;
            cap_off_q <= cap_off_d;
            rw_out_q  <= rw_out_d;
            rd_out_q  <= rd_out_d;
            wdata_q   <= wdata_d;
            instret_q <= instret_d;
        end
    end

    assign regWrite_WB_out  = rw_out_q;
    assign rd_WB_out        = rd_out_q;
    assign writeData_WB_out = wdata_q;
    assign instret_WB_out   = instret_q;

endmodule

// File: tb/tb_wb_stage_param.sv
// Bench for wb_stage_param: three instances (RV32, RV64, RV32 with a 4-bit
// counter) share one stimulus stream and are checked against a behavioural
// model that tracks at most one pending load.
module tb_wb_stage_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid, flush, rw_in, rv;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [4:0]  rd_in;
    logic [63:0] alu, pc4, imm, rdata;

    logic        ready32, rw32, lw32;
    logic [4:0]  rd32;
    logic [31:0] wd32;
    logic [63:0] ic32;
    logic        ready64, rw64, lw64;
    logic [4:0]  rd64;
    logic [63:0] wd64;
    logic [63:0] ic64;
    logic        readyc, rwc, lwc;
    logic [4:0]  rdc;
    logic [31:0] wdc;
    logic [3:0]  icc;

    int total = 0;
    int bad   = 0;

    // Model state
    bit              m_pend;
    bit              m_p_rw;
    logic [4:0]      m_p_rd;
    logic [2:0]      m_p_lt;
    logic [63:0]     m_p_addr;
    bit              m_rw;
    logic [4:0]      m_rd;
    logic [63:0]     m_w32, m_w64;
    longint unsigned m_cnt;

    always #5 clock = ~clock;

    wb_stage_param #(.XLEN(32), .CNT_W(64), .REG_AW(5)) dut32 (
        .clock(clock), .reset(reset), .valid_WB_in(valid), .ready_WB_out(ready32),
        .flush_WB_in(flush), .regWrite_WB_in(rw_in), .wbSel_WB_in(sel),
        .loadType_WB_in(lt), .rd_WB_in(rd_in), .ALU_result_WB_in(alu[31:0]),
        .pcPlus4_WB_in(pc4[31:0]), .imm_WB_in(imm[31:0]), .readData_WB_in(rdata[31:0]),
        .readValid_WB_in(rv), .regWrite_WB_out(rw32), .rd_WB_out(rd32),
        .writeData_WB_out(wd32), .loadWait_WB_out(lw32), .instret_WB_out(ic32));

    wb_stage_param #(.XLEN(64), .CNT_W(64), .REG_AW(5)) dut64 (
        .clock(clock), .reset(reset), .valid_WB_in(valid), .ready_WB_out(ready64),
        .flush_WB_in(flush), .regWrite_WB_in(rw_in), .wbSel_WB_in(sel),
        .loadType_WB_in(lt), .rd_WB_in(rd_in), .ALU_result_WB_in(alu),
        .pcPlus4_WB_in(pc4), .imm_WB_in(imm), .readData_WB_in(rdata),
        .readValid_WB_in(rv), .regWrite_WB_out(rw64), .rd_WB_out(rd64),
        .writeData_WB_out(wd64), .loadWait_WB_out(lw64), .instret_WB_out(ic64));

    wb_stage_param #(.XLEN(32), .CNT_W(4), .REG_AW(5)) dutc (
        .clock(clock), .reset(reset), .valid_WB_in(valid), .ready_WB_out(readyc),
        .flush_WB_in(flush), .regWrite_WB_in(rw_in), .wbSel_WB_in(sel),
        .loadType_WB_in(lt), .rd_WB_in(rd_in), .ALU_result_WB_in(alu[31:0]),
        .pcPlus4_WB_in(pc4[31:0]), .imm_WB_in(imm[31:0]), .readData_WB_in(rdata[31:0]),
        .readValid_WB_in(rv), .regWrite_WB_out(rwc), .rd_WB_out(rdc),
        .writeData_WB_out(wdc), .loadWait_WB_out(lwc), .instret_WB_out(icc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load result from the RISC-V rules, by byte arithmetic on the word.
    function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] raw_in,
                                             input logic [63:0] addr, input logic [2:0] t);
        logic [63:0] mask, raw;
        int          off;
        longint      v;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        raw  = raw_in & mask;
        off  = int'(addr % 64'(xlen / 8));
        case (t)
            3'd0: begin
                v = longint'((raw >> (8 * off)) & 64'hFF);
                if (v >= 128) v -= 256;
            end
            3'd4: v = longint'((raw >> (8 * off)) & 64'hFF);
            3'd1, 3'd5: begin
                off = off - (off % 2);
                v = longint'((raw >> (8 * off)) & 64'hFFFF);
                if (t == 3'd1 && v >= 32768) v -= 65536;
            end
            3'd2: begin
                off = (xlen == 64) ? off - (off % 4) : 0;
                v = longint'((raw >> (8 * off)) & 64'hFFFF_FFFF);
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            3'd6: begin
                if (xlen == 64) begin
                    off = off - (off % 4);
                    v = longint'((raw >> (8 * off)) & 64'hFFFF_FFFF);
                end else begin
                    v = longint'(raw);
                end
            end
            default: v = longint'(raw);
        endcase
        return 64'(v) & mask;
    endfunction

    function automatic logic [63:0] live_value(input int xlen);
        logic [63:0] mask;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (sel)
            2'd0:    return alu & mask;
            2'd1:    return ref_load(xlen, rdata, alu, lt);
            2'd2:    return pc4 & mask;
            default: return imm & mask;
        endcase
    endfunction

    task automatic retire_ref(input bit rw, input logic [4:0] rd,
                              input logic [63:0] d32, input logic [63:0] d64);
        m_rw  = rw && (rd != 5'd0);
        m_rd  = rd;
        m_w32 = d32;
        m_w64 = d64;
        m_cnt = m_cnt + 1;
    endtask

    // Predict post-edge outputs from the inputs present before the edge.
    task automatic model_update();
        if (reset) begin
            m_pend = 0; m_rw = 0; m_rd = '0; m_w32 = '0; m_w64 = '0; m_cnt = 0;
        end else begin
            m_rw = 0;
            if (m_pend) begin
                if (flush) begin
                    m_pend = 0;
                end else if (rv) begin
                    retire_ref(m_p_rw, m_p_rd, ref_load(32, rdata, m_p_addr, m_p_lt),
                               ref_load(64, rdata, m_p_addr, m_p_lt));
                    m_pend = 0;
                end
            end else if (valid && !flush) begin
                if (sel != 2'd1 || rv) begin
                    retire_ref(rw_in, rd_in, live_value(32), live_value(64));
                end else begin
                    m_pend = 1; m_p_rw = rw_in; m_p_rd = rd_in; m_p_lt = lt; m_p_addr = alu;
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        chk("ready32", ready32, !m_pend);
        chk("wait32", lw32, m_pend);
        chk("rw32", rw32, m_rw);
        chk("rd32", rd32, m_rd);
        chk("wd32", wd32, m_w32);
        chk("cnt32", ic32, m_cnt);
        chk("ready64", ready64, !m_pend);
        chk("wait64", lw64, m_pend);
        chk("rw64", rw64, m_rw);
        chk("rd64", rd64, m_rd);
        chk("wd64", wd64, m_w64);
        chk("cnt64", ic64, m_cnt);
        chk("readyc", readyc, !m_pend);
        chk("rwc", rwc, m_rw);
        chk("wdc", wdc, m_w32);
        chk("cntc", icc, m_cnt % 16);
    endtask

    task automatic drive(input bit v, input bit f, input bit w, input logic [1:0] s,
                         input logic [2:0] t, input logic [4:0] r, input logic [63:0] a,
                         input logic [63:0] d, input bit valid_rsp);
        valid = v; flush = f; rw_in = w; sel = s; lt = t; rd_in = r;
        alu = a; rdata = d; rv = valid_rsp;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 2'd0, 3'd0, 5'd0, 64'd0, 64'd0, 0);
    endtask

    initial begin
        reset = 1; pc4 = '0; imm = '0;
        idle_in();
        step();
        chk("reset_rd", rd32, 0);
        reset = 0;

        // ALU path
        drive(1, 0, 1, 2'd0, 3'd0, 5'd5, 64'h1234, 64'd0, 0);
        step();
        chk("alu_data", wd32, 64'h1234);
        chk("alu_cnt", ic32, 1);

        // Load extension, immediate response
        drive(1, 0, 1, 2'd1, 3'd0, 5'd3, 64'd3, 64'h80FF_7F01, 1);
        step();
        chk("lb", wd32, 64'hFFFF_FF80);
        drive(1, 0, 1, 2'd1, 3'd4, 5'd3, 64'd2, 64'h80FF_7F01, 1);
        step();
        chk("lbu", wd32, 64'h0000_00FF);
        drive(1, 0, 1, 2'd1, 3'd1, 5'd3, 64'd2, 64'h80FF_7F01, 1);
        step();
        chk("lh", wd32, 64'hFFFF_80FF);

        // Waited load: three cycles in WAIT_MEM, response on the third
        drive(1, 0, 1, 2'd1, 3'd2, 5'd7, 64'h40, 64'd0, 0);
        step();
        idle_in(); step(); step();
        drive(0, 0, 0, 2'd0, 3'd0, 5'd0, 64'd0, 64'hAB, 1);
        step();
        chk("lw_wait_data", wd32, 64'hAB);
        chk("lw_wait_rd", rd32, 7);
        chk("lw_wait_ready", ready32, 1);

        // x0 suppression
        pc4 = 64'h100;
        drive(1, 0, 1, 2'd2, 3'd0, 5'd0, 64'd0, 64'd0, 0);
        step();
        chk("x0_rw", rw32, 0);
        chk("x0_data", wd32, 64'h100);

        // Flush in WAIT_MEM with same-cycle response
        drive(1, 0, 1, 2'd1, 3'd2, 5'd9, 64'd0, 64'd0, 0);
        step();
        drive(0, 1, 0, 2'd0, 3'd0, 5'd0, 64'd0, 64'h55, 1);
        step();
        chk("flush_rw", rw32, 0);

        // Reset in WAIT_MEM
        drive(1, 0, 1, 2'd1, 3'd2, 5'd9, 64'd0, 64'd0, 0);
        step();
        idle_in();
        reset = 1;
        step();
        reset = 0;
        chk("rst_wait_ready", ready32, 1);
        chk("rst_wait_cnt", ic32, 0);

        // RV64 word loads
        drive(1, 0, 1, 2'd1, 3'd2, 5'd4, 64'd4, 64'h8000_0001_FFFF_FFFE, 1);
        step();
        chk("ld64_lw", wd64, 64'hFFFF_FFFF_8000_0001);
        drive(1, 0, 1, 2'd1, 3'd6, 5'd4, 64'd0, 64'h8000_0001_FFFF_FFFE, 1);
        step();
        chk("ld64_lwu", wd64, 64'h0000_0000_FFFF_FFFE);

        // Counter wrap on the 4-bit instance
        idle_in();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 1, 2'd3, 3'd0, 5'(i), 64'd0, 64'd0, 0);
            imm = 64'(i);
            step();
        end
        chk("wrap_cnt", icc, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            rw_in = $urandom_range(0, 1);
            sel   = 2'($urandom_range(0, 3));
            lt    = 3'($urandom_range(0, 7));
            rd_in = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu   = {$urandom, $urandom};
            pc4   = {$urandom, $urandom};
            imm   = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rv    = $urandom_range(0, 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
